// File: rtl/dff_chain_ctrl.sv
// dff_chain_ctrl
//   Parallel-load / serial-shift controller around a WIDTH-bit chain of D
//   flip-flops. A start request in IDLE loads the chain. The chain is then
//   shifted out MSB-first for WIDTH edges while serial_in is shifted in at
//   the LSB. The captured word is presented on dout, with done high for one
//   cycle.
//
//   Optional build macro: DFF_CHAIN_CTRL_PARITY_EN
//     When defined, this adds a registered even-parity output (parity) for the
//     word written to dout. When undefined, the port and its register are absent.
//
//   WIDTH legal range: 2..32.
//
//   Every output is decoded from registered state only. No input reaches an
//   output combinationally.

module dff_chain_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] load_data,
    input  logic             serial_in,
    output logic             serial_out,
    output logic [WIDTH-1:0] dout,
    output logic             busy,
    output logic             done
`ifdef DFF_CHAIN_CTRL_PARITY_EN
    ,
    output logic             parity
`endif
);

    // Counter just wide enough to count the WIDTH shift edges (0..WIDTH-1).
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [WIDTH-1:0] r_chain;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_dout;

    logic             w_load;       // start accepted in IDLE this edge
    logic             w_shift;      // chain shifts this edge
    logic             w_last;       // final shift edge of the transfer
    logic [WIDTH-1:0] w_shifted;    // chain contents after one shift step
    logic [WIDTH-1:0] w_chain_next; // next value of each flip-flop in the chain

    assign w_load  = (r_state == S_IDLE) && start;
    assign w_shift = (r_state == S_SHIFT);
    assign w_last  = w_shift && (r_cnt == CNT_LAST);

    // Per-bit next-state logic for the flip-flop chain.
    // Bit 0 takes serial_in; every other bit takes its lower neighbour.
    // A load overrides the shift. Outside load and shift, each bit holds.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_chain_bit
            if (gi == 0) begin : g_lsb
                assign w_shifted[gi] = serial_in;
            end else begin : g_upper
                assign w_shifted[gi] = r_chain[gi-1];
            end
            assign w_chain_next[gi] = w_load  ? load_data[gi] :
                                      w_shift ? w_shifted[gi] :
                                                r_chain[gi];
        end
    endgenerate

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode.
    // DONE lasts exactly one cycle. A start seen in SHIFT or DONE is dropped.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (r_cnt == CNT_LAST) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Output decode.
    // serial_out exposes the chain MSB only while shifting.
    always_comb begin
        serial_out = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                serial_out = 1'b0;
                busy       = 1'b0;
                done       = 1'b0;
            end
            S_SHIFT: begin
                serial_out = r_chain[WIDTH-1];
                busy       = 1'b1;
                done       = 1'b0;
            end
            S_DONE: begin
                serial_out = 1'b0;
                busy       = 1'b1;
                done       = 1'b1;
            end
            default: begin
                serial_out = 1'b0;
                busy       = 1'b0;
                done       = 1'b0;
            end
        endcase
    end

    // Flip-flop chain. It is cleared on reset and otherwise follows the
    // per-bit next-state logic.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_chain <= '0;
        end else begin
            r_chain <= w_chain_next;
        end
    end

    // Shift counter. It is zeroed on load and on the final shift, and
    // advances on every other shift edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_load || w_last) begin
            r_cnt <= '0;
        end else if (w_shift) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // Captured word. It is written only on the final shift edge and
    // otherwise holds, including through the next transfer's shifting.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_dout <= '0;
        end else if (w_last) begin
            r_dout <= w_shifted;
        end
    end

    assign dout = r_dout;

`ifdef DFF_CHAIN_CTRL_PARITY_EN
    logic r_parity;

    // Even parity of the word being written to dout.
    // It is registered on the same edge as dout, so the two stay paired.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_parity <= 1'b0;
        end else if (w_last) begin
            r_parity <= ^w_shifted;
        end
    end

    assign parity = r_parity;
`endif

endmodule

// File: tb/tb_dff_chain_ctrl.sv
// Directed self-checking bench for dff_chain_ctrl (WIDTH=8).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.

`timescale 1ns/1ps

module tb_dff_chain_ctrl;

    localparam int WIDTH = 8;

    logic             clock;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] load_data;
    logic             serial_in;
    logic             serial_out;
    logic [WIDTH-1:0] dout;
    logic             busy;
    logic             done;
`ifdef DFF_CHAIN_CTRL_PARITY_EN
    logic             parity;
`endif

    int errors = 0;
    int checks = 0;

    dff_chain_ctrl #(.WIDTH(WIDTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .load_data (load_data),
        .serial_in (serial_in),
        .serial_out(serial_out),
        .dout      (dout),
        .busy      (busy),
        .done      (done)
`ifdef DFF_CHAIN_CTRL_PARITY_EN
        ,
        .parity    (parity)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one rising edge, then settle.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; load_data = 8'hFF; serial_in = 1'b1;
        tick();
        tick();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++;
        if (serial_out !== 1'b0) begin errors++; $display("FAIL reset_sout: got %b want 0", serial_out); end
        reset = 1'b0; start = 1'b0; serial_in = 1'b0;
        tick();
        checks++;
        if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h want 00", dout); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
`ifdef DFF_CHAIN_CTRL_PARITY_EN
        checks++;
        if (parity !== 1'b0) begin errors++; $display("FAIL reset_parity: got %b want 0", parity); end
`endif
        $display("test_reset: done");
    endtask

    task automatic test_loopback();
        logic [7:0] ld;
        int         done_cnt;
        ld = 8'hA5;
        done_cnt = 0;
        start = 1'b1; load_data = ld;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            if (c <= 8) begin
                checks++;
                if (serial_out !== ld[8-c]) begin
                    errors++; $display("FAIL loop_sout c=%0d: got %b want %b", c, serial_out, ld[8-c]);
                end
            end
            checks++;
            if (done !== (c == 9)) begin
                errors++; $display("FAIL loop_done c=%0d: got %b want %b", c, done, (c == 9));
            end
            checks++;
            if (busy !== (c <= 9)) begin
                errors++; $display("FAIL loop_busy c=%0d: got %b want %b", c, busy, (c <= 9));
            end
            if (done === 1'b1) done_cnt++;
            serial_in = serial_out;
            tick();
        end
        checks++;
        if (dout !== 8'hA5) begin errors++; $display("FAIL loop_dout: got %h want a5", dout); end
        checks++;
        if (done_cnt != 1) begin errors++; $display("FAIL loop_done_count: got %0d want 1", done_cnt); end
        $display("test_loopback: load=a5 dout=%h", dout);
    endtask

    task automatic test_capture_ones();
        start = 1'b1; load_data = 8'h00; serial_in = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            if (c <= 8) begin
                checks++;
                if (serial_out !== 1'b0) begin
                    errors++; $display("FAIL ones_sout c=%0d: got %b want 0", c, serial_out);
                end
            end
            tick();
        end
        checks++;
        if (dout !== 8'hFF) begin errors++; $display("FAIL ones_dout: got %h want ff", dout); end
        serial_in = 1'b0;
        tick();
        $display("test_capture_ones: dout=%h", dout);
    endtask

    task automatic test_capture_pattern();
        logic [7:0] pat;
        logic [7:0] ld;
        pat = 8'hC3;  // bits 1,1,0,0,0,0,1,1 sent in time order
        ld  = 8'h5A;
        start = 1'b1; load_data = ld;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            checks++;
            if (serial_out !== ld[8-c]) begin
                errors++; $display("FAIL pat_sout c=%0d: got %b want %b", c, serial_out, ld[8-c]);
            end
            serial_in = pat[8-c];
            tick();
        end
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL pat_done: got %b want 1", done); end
        checks++;
        if (dout !== 8'hC3) begin errors++; $display("FAIL pat_dout: got %h want c3", dout); end
        serial_in = 1'b0;
        tick();
        $display("test_capture_pattern: dout=%h", dout);
    endtask

    task automatic test_start_while_busy();
        logic [7:0] ld;
        int         done_cnt;
        ld = 8'h96;
        done_cnt = 0;
        start = 1'b1; load_data = ld;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 13; c++) begin
            if (c <= 8) begin
                checks++;
                if (serial_out !== ld[8-c]) begin
                    errors++; $display("FAIL busy_sout c=%0d: got %b want %b", c, serial_out, ld[8-c]);
                end
            end
            if (c == 3 || c == 4) begin
                start = 1'b1; load_data = 8'h3C;
            end else begin
                start = 1'b0;
            end
            if (c == 9) begin
                checks++;
                if (done !== 1'b1) begin errors++; $display("FAIL busy_done_time: got %b want 1", done); end
            end
            if (done === 1'b1) done_cnt++;
            serial_in = serial_out;
            tick();
        end
        checks++;
        if (done_cnt != 1) begin errors++; $display("FAIL busy_done_count: got %0d want 1", done_cnt); end
        checks++;
        if (dout !== 8'h96) begin errors++; $display("FAIL busy_dout: got %h want 96", dout); end
        $display("test_start_while_busy: dout=%h done_count=%0d", dout, done_cnt);
    endtask

    task automatic test_back_to_back();
        logic [7:0] ld1;
        logic [7:0] ld2;
        ld1 = 8'h5C;
        ld2 = 8'hE7;
        start = 1'b1; load_data = ld1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            serial_in = serial_out;
            tick();
        end
        // c=10: the IDLE cycle after DONE.
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_busy: got %b want 0", busy); end
        checks++;
        if (dout !== ld1) begin errors++; $display("FAIL b2b_first_dout: got %h want %h", dout, ld1); end
        start = 1'b1; load_data = ld2;
        tick();
        start = 1'b0; load_data = 8'h00;
        for (int c = 1; c <= 9; c++) begin
            if (c <= 8) begin
                checks++;
                if (serial_out !== ld2[8-c]) begin
                    errors++; $display("FAIL b2b_sout c=%0d: got %b want %b", c, serial_out, ld2[8-c]);
                end
                checks++;
                if (dout !== ld1) begin
                    errors++; $display("FAIL b2b_hold c=%0d: got %h want %h", c, dout, ld1);
                end
            end else begin
                checks++;
                if (done !== 1'b1) begin errors++; $display("FAIL b2b_done2: got %b want 1", done); end
                checks++;
                if (dout !== ld2) begin errors++; $display("FAIL b2b_second_dout: got %h want %h", dout, ld2); end
            end
            serial_in = serial_out;
            tick();
        end
        $display("test_back_to_back: first=%h second=%h", ld1, dout);
    endtask

    task automatic test_reset_mid();
        int done_cnt;
        done_cnt = 0;
        start = 1'b1; load_data = 8'h3C;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            serial_in = serial_out;
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b want 0", busy); end
        checks++;
        if (dout !== 8'h00) begin errors++; $display("FAIL mid_dout: got %h want 00", dout); end
        checks++;
        if (serial_out !== 1'b0) begin errors++; $display("FAIL mid_sout: got %b want 0", serial_out); end
        for (int c = 0; c < 10; c++) begin
            if (done === 1'b1) done_cnt++;
            tick();
        end
        checks++;
        if (done_cnt != 0) begin errors++; $display("FAIL mid_no_done: got %0d want 0", done_cnt); end
        start = 1'b1; load_data = 8'h81;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            serial_in = serial_out;
            tick();
        end
        checks++;
        if (dout !== 8'h81) begin errors++; $display("FAIL mid_after_dout: got %h want 81", dout); end
        $display("test_reset_mid: dout after restart=%h", dout);
    endtask

`ifdef DFF_CHAIN_CTRL_PARITY_EN
    task automatic test_parity();
        logic [7:0] words [2];
        logic       want  [2];
        words[0] = 8'hA5; want[0] = 1'b0;
        words[1] = 8'hA4; want[1] = 1'b1;
        for (int k = 0; k < 2; k++) begin
            start = 1'b1; load_data = words[k];
            tick();
            start = 1'b0;
            for (int c = 1; c <= 9; c++) begin
                serial_in = serial_out;
                tick();
            end
            checks++;
            if (dout !== words[k]) begin errors++; $display("FAIL par_dout: got %h want %h", dout, words[k]); end
            checks++;
            if (parity !== want[k]) begin errors++; $display("FAIL par_bit: got %b want %b", parity, want[k]); end
            tick();
            checks++;
            if (parity !== want[k]) begin errors++; $display("FAIL par_hold: got %b want %b", parity, want[k]); end
            $display("test_parity: dout=%h parity=%b", dout, parity);
        end
    endtask
`endif

    // Watchdog. A stuck run ends with a report line instead of hanging.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; start = 1'b0; load_data = '0; serial_in = 1'b0;
        test_reset();
        test_loopback();
        test_capture_ones();
        test_capture_pattern();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid();
`ifdef DFF_CHAIN_CTRL_PARITY_EN
        test_parity();
`else
        $display("parity port not built in this configuration");
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
